// File: rtl/bitmask_scanner.sv
// bitmask_scanner: walks the set bits of an 8-bit essential-bit mask MSB-first,
// one encoder-convention index (idx 0 = bit 7) per accepted output beat.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready/in_mask/in_tag   mask input handshake
//   out_valid/out_ready                beat output handshake
//   out_idx, out_tag                   beat index and sideband tag
//   out_first, out_last, out_zero      beat framing flags
//
// Optional feature macro: BITMASK_SCANNER_SKIP_ZERO_EN
//   defined   -> all-zero masks are consumed silently (no beat, out_zero tied 0)
//   undefined -> an all-zero mask yields one beat with out_zero=1

module p_encoder_8to3 (
  input  logic [7:0] data,
  output logic [2:0] idx,
  output logic       is_zero
);

  always_comb begin
    idx     = 3'd0;
    is_zero = 1'b0;
    priority case (1'b1)
      data[7]: idx = 3'd0;
      data[6]: idx = 3'd1;
      data[5]: idx = 3'd2;
      data[4]: idx = 3'd3;
      data[3]: idx = 3'd4;
      data[2]: idx = 3'd5;
      data[1]: idx = 3'd6;
      data[0]: idx = 3'd7;
      default: is_zero = 1'b1;
    endcase
  end

endmodule

module bitmask_scanner #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mask,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_first,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             first_q, first_d;

  logic [2:0] enc_idx;
  logic       enc_zero;
  logic       scan;
  logic       last;
  logic       fire;
  logic       done;
  logic       take;
  logic       drop_zero;

  p_encoder_8to3 u_enc (
    .data    (res_q),
    .idx     (enc_idx),
    .is_zero (enc_zero)
  );

  assign scan = (state_q == SCAN);

  // popcount <= 1: clearing the lowest set bit leaves nothing
  assign last = ((res_q & (res_q - 8'd1)) == 8'd0);

  assign fire     = scan & out_ready;
  assign done     = fire & last;
  assign in_ready = ~scan | done;
  assign take     = in_valid & in_ready;

`ifdef BITMASK_SCANNER_SKIP_ZERO_EN
  assign drop_zero = (in_mask == 8'd0);
`else
  assign drop_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    tag_d   = tag_q;
    first_d = first_q;
    if (fire && !last) begin
      // idx k reports mask bit 7-k
      res_d   = res_q & ~(8'h80 >> enc_idx);
      first_d = 1'b0;
    end
    if (done) begin
      state_d = IDLE;
      res_d   = 8'd0;
      first_d = 1'b0;
    end
    if (take) begin
      if (drop_zero) begin
        state_d = IDLE;
        res_d   = 8'd0;
        first_d = 1'b0;
      end else begin
        state_d = SCAN;
        res_d   = in_mask;
        tag_d   = in_tag;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= 8'd0;
      tag_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      first_q <= first_d;
    end
  end

  // outputs are forced quiet outside SCAN
  assign out_valid = scan;
  assign out_idx   = scan ? enc_idx : 3'd0;
  assign out_tag   = scan ? tag_q : '0;
  assign out_first = scan & first_q;
  assign out_last  = scan & last;

`ifdef BITMASK_SCANNER_SKIP_ZERO_EN
  assign out_zero = 1'b0;
`else
  assign out_zero = scan & enc_zero;
`endif

endmodule

// File: tb/tb_bitmask_scanner.sv
// tb_bitmask_scanner: table vectors, hand sequences and a scoreboard
// for bitmask_scanner.

module tb_bitmask_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_mask = 8'd0;
  logic [7:0] in_tag = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_idx;
  logic [7:0] out_tag;
  logic       out_first;
  logic       out_last;
  logic       out_zero;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int rmode = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] tag;
    logic       first;
    logic       last;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] tag;
    int         nbeats;
  } vec_t;

  exp_t sbq[$];

  bitmask_scanner #(.TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_tag   (out_tag),
    .out_first (out_first),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_mask(logic [7:0] m, logic [7:0] t);
    exp_t e;
    int n;
    int c;
    n = 0;
    c = 0;
    for (int b = 7; b >= 0; b--) if (m[b]) n++;
    for (int b = 7; b >= 0; b--) begin
      if (m[b]) begin
        c++;
        e.idx = 3'(7 - b);
        e.tag = t;
        e.first = (c == 1);
        e.last = (c == n);
        e.zero = 1'b0;
        sbq.push_back(e);
      end
    end
`ifndef BITMASK_SCANNER_SKIP_ZERO_EN
    if (n == 0) begin
      e.idx = 3'd0;
      e.tag = t;
      e.first = 1'b1;
      e.last = 1'b1;
      e.zero = 1'b1;
      sbq.push_back(e);
    end
`endif
  endfunction

  // out_ready pattern: 0 always ready, 1 toggle, 2 random
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("sb_idx", out_idx, sbq[0].idx);
          chk("sb_tag", out_tag, sbq[0].tag);
          chk("sb_first", out_first, sbq[0].first);
          chk("sb_last", out_last, sbq[0].last);
          chk("sb_zero", out_zero, sbq[0].zero);
          if (out_ready) begin
            void'(sbq.pop_front());
            beats++;
          end
        end
      end
      if (in_valid && in_ready) push_mask(in_mask, in_tag);
    end
  end

  task automatic send(logic [7:0] m, logic [7:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mask = m;
    in_tag = t;
    #1;
    while (!in_ready && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  vec_t vt[7];
  int base;

  initial begin
    vt[0] = '{8'h80, 8'h01, 1};
    vt[1] = '{8'h01, 8'h02, 1};
    vt[2] = '{8'h55, 8'h03, 4};
    vt[3] = '{8'hFF, 8'h04, 8};
    vt[4] = '{8'h18, 8'h05, 2};
    vt[5] = '{8'hC3, 8'h06, 4};
`ifdef BITMASK_SCANNER_SKIP_ZERO_EN
    vt[6] = '{8'h00, 8'h07, 0};
`else
    vt[6] = '{8'h00, 8'h07, 1};
`endif

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_zero", out_zero, 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first mask: latency 1, idx 0,2,5
    base = beats;
    send(8'hA4, 8'h3C);
    #1;
    chk("a4_valid", out_valid, 1);
    chk("a4_idx0", out_idx, 0);
    chk("a4_first", out_first, 1);
    chk("a4_tag", out_tag, 8'h3C);
    wait_idle();
    chk("a4_beats", beats - base, 3);

    // table vectors, always ready
    foreach (vt[i]) begin
      base = beats;
      send(vt[i].mask, vt[i].tag);
      wait_idle();
      chk($sformatf("tbl%0d_beats", i), beats - base, vt[i].nbeats);
    end

    // 0xFF with toggling ready
    rmode = 1;
    base = beats;
    send(8'hFF, 8'h5A);
    wait_idle();
    chk("ff_toggle_beats", beats - base, 8);
    rmode = 0;
    @(posedge clk);
    #1;

    // back-to-back 0x01 then 0x80
    base = beats;
    in_valid = 1'b1;
    in_mask = 8'h01;
    in_tag = 8'h11;
    #1;
    chk("b2b_ready0", in_ready, 1);
    @(posedge clk);
    #1;
    in_mask = 8'h80;
    in_tag = 8'h22;
    #1;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_idx1", out_idx, 7);
    chk("b2b_last1", out_last, 1);
    chk("b2b_ready1", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_idx2", out_idx, 0);
    chk("b2b_first2", out_first, 1);
    chk("b2b_tag2", out_tag, 8'h22);
    wait_idle();
    chk("b2b_beats", beats - base, 2);

    // zero mask
    send(8'h00, 8'h99);
    #1;
`ifdef BITMASK_SCANNER_SKIP_ZERO_EN
    chk("zero_no_beat", out_valid, 0);
    chk("zero_ready", in_ready, 1);
`else
    chk("zero_valid", out_valid, 1);
    chk("zero_flag", out_zero, 1);
    chk("zero_idx", out_idx, 0);
    chk("zero_first", out_first, 1);
    chk("zero_last", out_last, 1);
`endif
    wait_idle();

    // reset mid-scan of 0xF0 after 2 beats
    base = beats;
    send(8'hF0, 8'h77);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_beats", beats - base, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = beats;
    send(8'h08, 8'h44);
    #1;
    chk("post_rst_idx", out_idx, 4);
    chk("post_rst_last", out_last, 1);
    wait_idle();
    chk("post_rst_beats", beats - base, 1);

    // random masks, tags and backpressure
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom));
      if ((i % 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rmode = 0;
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
